// File: rtl/toy_pack.sv
// Shared types and constants for the icache prefetch path: request payload,
// prefetcher FSM states and the cache line-address type.
package toy_pack;

    localparam int ADDR_WIDTH               = 32;
    localparam int ICACHE_REQ_TXNID_WIDTH   = 8;
    localparam int ICACHE_LINE_OFFSET_WIDTH = 6;
    localparam int ICACHE_PAGE_OFFSET_WIDTH = 12;
    localparam int OPCODE_WIDTH             = 3;

    typedef logic [ADDR_WIDTH-1:0]             req_addr_t;
    typedef logic [ICACHE_REQ_TXNID_WIDTH-1:0] req_txnid_t;
    typedef logic [OPCODE_WIDTH-1:0]           req_opcode_t;

    typedef logic [ADDR_WIDTH-ICACHE_LINE_OFFSET_WIDTH-1:0] icache_line_addr_t;

    localparam req_opcode_t PREF_OPCODE = 3'd4;

    typedef struct packed {
        req_addr_t   addr;
        req_txnid_t  txnid;
        req_opcode_t opcode;
    } pc_req_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } pref_state_e;

endpackage

// File: rtl/icache_pref_line_filter.sv
// Small fully associative filter of recently issued prefetch line addresses;
// combinational hit, round-robin replacement, single-cycle flush.
module icache_pref_line_filter
    import toy_pack::*;
#(
    parameter int FILTER_NUM = 4,
    parameter int LA_W       = ADDR_WIDTH - ICACHE_LINE_OFFSET_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [LA_W-1:0] lookup_la,
    output logic            hit,
    input  logic            insert_vld,
    input  logic [LA_W-1:0] insert_la
);

    localparam int PTR_W = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1;

    logic [FILTER_NUM-1:0] valid_q;
    logic [LA_W-1:0]       la_q [FILTER_NUM];
    logic [PTR_W-1:0]      ptr_q;

    // NOTE: default assigned before the loop so hit is fully specified and no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FILTER_NUM; i++) begin
            if (valid_q[i] && (la_q[i] == lookup_la)) begin
                hit = 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (insert_vld) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= (ptr_q == PTR_W'(FILTER_NUM - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // NOTE: address storage is left unreset; valid_q alone decides whether an entry can hit.
    always_ff @(posedge clk) begin
        if (insert_vld && !flush) begin
            la_q[ptr_q] <= insert_la;
        end
    end

endmodule

// File: rtl/icache_stream_prefetcher.sv
// Next-line stream prefetcher: each demand miss launches up to PREF_DEPTH
// sequential line prefetches within the miss page, filtered and MSHR-gated.
module icache_stream_prefetcher
    import toy_pack::*;
#(
    parameter int PREF_DEPTH        = 2,
    parameter int FILTER_NUM        = 4,
    parameter int LINE_OFFSET_WIDTH = ICACHE_LINE_OFFSET_WIDTH,
    parameter int PAGE_OFFSET_WIDTH = ICACHE_PAGE_OFFSET_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       prefetch_enable,
    input  logic       miss_for_prefetch,
    input  req_addr_t  miss_addr_for_prefetch,
    input  req_txnid_t miss_txnid_for_prefetch,
    input  logic       pref_to_mshr_req_rdy,
    output logic       prefetch_req_vld,
    input  logic       prefetch_req_rdy,
    output pc_req_t    prefetch_req_pld
);

    localparam int LA_W  = ADDR_WIDTH - LINE_OFFSET_WIDTH;
    localparam int PG_SH = PAGE_OFFSET_WIDTH - LINE_OFFSET_WIDTH;
    localparam int CNT_W = $clog2(PREF_DEPTH + 1);

    typedef logic [LA_W-1:0]  la_t;
    typedef logic [CNT_W-1:0] cnt_t;

    pref_state_e state_q, state_d;
    la_t         base_la_q, base_la_d;
    req_txnid_t  txnid_q, txnid_d;
    cnt_t        count_q, count_d;
    logic        pend_vld_q, pend_vld_d;
    la_t         pend_la_q, pend_la_d;
    req_txnid_t  pend_txnid_q, pend_txnid_d;
    logic        vld_q, vld_d;
    pc_req_t     pld_q, pld_d;

    la_t        miss_la;
    logic       miss_offset_unused;
    logic       start_miss, start_pend, cont, eval;
    la_t        eff_base_la, cand_la;
    req_txnid_t eff_txnid;
    cnt_t       eff_count;
    logic       filter_hit;
    logic       insert_vld;

    assign miss_la            = miss_addr_for_prefetch[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
    assign miss_offset_unused = ^miss_addr_for_prefetch[LINE_OFFSET_WIDTH-1:0];

    // A candidate is evaluated only with nothing outstanding; a fresh miss or the
    // pending miss restarts the stream and is evaluated in the same cycle.
    assign start_miss = prefetch_enable && !vld_q && (state_q == IDLE) && miss_for_prefetch;
    assign start_pend = prefetch_enable && !vld_q && !start_miss && pend_vld_q;
    assign cont       = prefetch_enable && !vld_q && (state_q == ISSUE) && !pend_vld_q
                        && (count_q < cnt_t'(PREF_DEPTH));
    assign eval       = start_miss || start_pend || cont;

    assign eff_base_la = start_miss ? miss_la : (start_pend ? pend_la_q : base_la_q);
    assign eff_txnid   = start_miss ? miss_txnid_for_prefetch
                                    : (start_pend ? pend_txnid_q : txnid_q);
    assign eff_count   = (start_miss || start_pend) ? '0 : count_q;
    assign cand_la     = eff_base_la + la_t'(eff_count) + la_t'(1);

    assign insert_vld  = prefetch_enable && vld_q && prefetch_req_rdy;

    icache_pref_line_filter #(
        .FILTER_NUM (FILTER_NUM),
        .LA_W       (LA_W)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (!prefetch_enable),
        .lookup_la  (cand_la),
        .hit        (filter_hit),
        .insert_vld (insert_vld),
        .insert_la  (pld_q.addr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_la_q    <= '0;
            txnid_q      <= '0;
            count_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_la_q    <= '0;
            pend_txnid_q <= '0;
            vld_q        <= 1'b0;
            pld_q        <= '0;
        end else begin
            state_q      <= state_d;
            base_la_q    <= base_la_d;
            txnid_q      <= txnid_d;
            count_q      <= count_d;
            pend_vld_q   <= pend_vld_d;
            pend_la_q    <= pend_la_d;
            pend_txnid_q <= pend_txnid_d;
            vld_q        <= vld_d;
            pld_q        <= pld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_la_d    = base_la_q;
        txnid_d      = txnid_q;
        count_d      = count_q;
        pend_vld_d   = pend_vld_q;
        pend_la_d    = pend_la_q;
        pend_txnid_d = pend_txnid_q;
        vld_d        = vld_q;
        pld_d        = pld_q;

        if (!prefetch_enable) begin
            pend_vld_d = 1'b0;
            if (!vld_q || prefetch_req_rdy) begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        end else if (vld_q) begin
            if (prefetch_req_rdy) begin
                vld_d   = 1'b0;
                count_d = count_q + cnt_t'(1);
            end
            if (miss_for_prefetch) begin
                pend_vld_d   = 1'b1;
                pend_la_d    = miss_la;
                pend_txnid_d = miss_txnid_for_prefetch;
            end
        end else begin
            if ((state_q == ISSUE) && !pend_vld_q && (count_q >= cnt_t'(PREF_DEPTH))) begin
                state_d = IDLE;
            end
            if (start_miss || start_pend) begin
                pend_vld_d = 1'b0;
            end
            if (miss_for_prefetch && !start_miss) begin
                pend_vld_d   = 1'b1;
                pend_la_d    = miss_la;
                pend_txnid_d = miss_txnid_for_prefetch;
            end
            if (eval) begin
                state_d   = ISSUE;
                base_la_d = eff_base_la;
                txnid_d   = eff_txnid;
                count_d   = eff_count;
                if (cand_la[LA_W-1:PG_SH] != eff_base_la[LA_W-1:PG_SH]) begin
                    state_d = IDLE;
                end else if (filter_hit) begin
                    count_d = eff_count + cnt_t'(1);
                end else if (pref_to_mshr_req_rdy) begin
                    vld_d        = 1'b1;
                    pld_d.addr   = {cand_la, {LINE_OFFSET_WIDTH{1'b0}}};
                    pld_d.txnid  = eff_txnid;
                    pld_d.opcode = PREF_OPCODE;
                end
            end
        end
    end

    assign prefetch_req_vld = vld_q;
    assign prefetch_req_pld = pld_q;

endmodule

// File: tb/tb_icache_stream_prefetcher.sv
// Directed bench for icache_stream_prefetcher: a stream-level reference model
// checked every cycle, plus hand-computed request lists per scenario.
module tb_icache_stream_prefetcher;
    import toy_pack::*;

    localparam int          PREF_DEPTH = 2;
    localparam int          FILTER_NUM = 4;
    localparam int unsigned LA_MASK    = 32'h03FF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prefetch_enable;
    logic       miss_for_prefetch;
    req_addr_t  miss_addr_for_prefetch;
    req_txnid_t miss_txnid_for_prefetch;
    logic       pref_to_mshr_req_rdy;
    logic       prefetch_req_vld;
    logic       prefetch_req_rdy;
    pc_req_t    prefetch_req_pld;

    int n_checks = 0;
    int n_err    = 0;

    int unsigned issued[$];

    icache_stream_prefetcher #(
        .PREF_DEPTH (PREF_DEPTH),
        .FILTER_NUM (FILTER_NUM)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .prefetch_enable         (prefetch_enable),
        .miss_for_prefetch       (miss_for_prefetch),
        .miss_addr_for_prefetch  (miss_addr_for_prefetch),
        .miss_txnid_for_prefetch (miss_txnid_for_prefetch),
        .pref_to_mshr_req_rdy    (pref_to_mshr_req_rdy),
        .prefetch_req_vld        (prefetch_req_vld),
        .prefetch_req_rdy        (prefetch_req_rdy),
        .prefetch_req_pld        (prefetch_req_pld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: stream bookkeeping in plain integers, filter as a FIFO of
    // the last FILTER_NUM accepted line addresses.
    bit          m_active;
    int          m_count;
    int unsigned m_base;
    req_txnid_t  m_base_txn;
    bit          m_pend;
    int unsigned m_pend_la;
    req_txnid_t  m_pend_txn;
    bit          m_vld;
    int unsigned m_addr;
    req_txnid_t  m_txn;
    int unsigned m_filt[$];
    int unsigned m_mla, m_cand;
    bit          m_go;

    function automatic bit recently_issued(input int unsigned la);
        foreach (m_filt[i]) if (m_filt[i] == la) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_count = 0; m_pend = 0; m_vld = 0; m_addr = 0; m_txn = '0;
            m_filt.delete();
        end else begin
            m_mla = miss_addr_for_prefetch >> 6;
            m_go  = 0;
            if (!prefetch_enable) begin
                m_filt.delete();
                m_pend = 0;
                if (!m_vld || prefetch_req_rdy) begin m_vld = 0; m_active = 0; end
            end else if (m_vld) begin
                if (prefetch_req_rdy) begin
                    m_vld = 0;
                    if (m_filt.size() == FILTER_NUM) void'(m_filt.pop_front());
                    m_filt.push_back(m_addr >> 6);
                    m_count++;
                end
                if (miss_for_prefetch) begin
                    m_pend = 1; m_pend_la = m_mla; m_pend_txn = miss_txnid_for_prefetch;
                end
            end else begin
                if (!m_active && miss_for_prefetch) begin
                    m_base = m_mla; m_base_txn = miss_txnid_for_prefetch;
                    m_count = 0; m_active = 1; m_pend = 0; m_go = 1;
                end else begin
                    if (m_pend) begin
                        m_base = m_pend_la; m_base_txn = m_pend_txn;
                        m_count = 0; m_active = 1; m_pend = 0; m_go = 1;
                    end else if (m_active) begin
                        if (m_count >= PREF_DEPTH) m_active = 0;
                        else m_go = 1;
                    end
                    if (miss_for_prefetch) begin
                        m_pend = 1; m_pend_la = m_mla; m_pend_txn = miss_txnid_for_prefetch;
                    end
                end
                if (m_go) begin
                    m_cand = (m_base + m_count + 1) & LA_MASK;
                    if ((m_cand >> 6) != (m_base >> 6)) m_active = 0;
                    else if (recently_issued(m_cand)) m_count++;
                    else if (pref_to_mshr_req_rdy) begin
                        m_vld = 1; m_addr = m_cand << 6; m_txn = m_base_txn;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_vld", prefetch_req_vld, m_vld);
            if (m_vld) begin
                check("cyc_addr", prefetch_req_pld.addr, m_addr);
                check("cyc_txnid", prefetch_req_pld.txnid, m_txn);
                check("cyc_opcode", prefetch_req_pld.opcode, PREF_OPCODE);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && prefetch_req_vld && prefetch_req_rdy) issued.push_back(prefetch_req_pld.addr);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_miss(input req_addr_t a, input req_txnid_t t);
        miss_for_prefetch       = 1'b1;
        miss_addr_for_prefetch  = a;
        miss_txnid_for_prefetch = t;
        @(negedge clk);
        miss_for_prefetch = 1'b0;
    endtask

    task automatic check_issued(input string name, input int unsigned exp[$]);
        check({name, "_count"}, issued.size(), exp.size());
        foreach (exp[i]) begin
            if (i < issued.size()) check({name, "_addr"}, issued[i], exp[i]);
        end
    endtask

    task automatic count_vld(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            if (prefetch_req_vld) hi++;
            @(negedge clk);
        end
    endtask

    initial begin
        int hi;
        rst_n                   = 1'b0;
        prefetch_enable         = 1'b1;
        miss_for_prefetch       = 1'b0;
        miss_addr_for_prefetch  = '0;
        miss_txnid_for_prefetch = '0;
        pref_to_mshr_req_rdy    = 1'b1;
        prefetch_req_rdy        = 1'b1;
        #1;
        check("reset_vld", prefetch_req_vld, 1'b0);
        check("reset_pld", prefetch_req_pld, '0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Basic stream: two sequential lines, first vld one cycle after the miss.
        pulse_miss(32'h1000_0040, 8'd5);
        check("basic_first_vld", prefetch_req_vld, 1'b1);
        check("basic_first_addr", prefetch_req_pld.addr, 32'h1000_0080);
        check("basic_first_txnid", prefetch_req_pld.txnid, 8'd5);
        check("basic_first_opcode", prefetch_req_pld.opcode, PREF_OPCODE);
        tick(6);
        check_issued("basic", '{32'h1000_0080, 32'h1000_00C0});
        check("basic_idle_vld", prefetch_req_vld, 1'b0);

        // Filter: 0x1000_00C0 was just issued and must be skipped.
        issued.delete();
        pulse_miss(32'h1000_0080, 8'd6);
        check("filter_skip_vld", prefetch_req_vld, 1'b0);
        tick(6);
        check_issued("filter", '{32'h1000_0100});

        // Page boundary: next line lies in the following page.
        issued.delete();
        pulse_miss(32'h1000_0FC0, 8'd1);
        count_vld(5, hi);
        check("page_no_vld", hi, 0);
        check("page_issued", issued.size(), 0);

        // MSHR gating.
        pref_to_mshr_req_rdy = 1'b0;
        pulse_miss(32'h3000_0000, 8'd2);
        count_vld(4, hi);
        check("mshr_gate_no_vld", hi, 0);
        pref_to_mshr_req_rdy = 1'b1;
        tick(1);
        check("mshr_release_vld", prefetch_req_vld, 1'b1);
        check("mshr_release_addr", prefetch_req_pld.addr, 32'h3000_0040);
        tick(6);
        check_issued("mshr", '{32'h3000_0040, 32'h3000_0080});

        // Disable with nothing outstanding: stream dropped, filter flushed.
        issued.delete();
        pref_to_mshr_req_rdy = 1'b0;
        pulse_miss(32'h4000_0000, 8'd3);
        prefetch_enable = 1'b0;
        tick(1);
        prefetch_enable      = 1'b1;
        pref_to_mshr_req_rdy = 1'b1;
        count_vld(4, hi);
        check("disable_no_vld", hi, 0);
        check("disable_issued", issued.size(), 0);
        pulse_miss(32'h3000_0000, 8'd4);
        check("reissue_addr", prefetch_req_pld.addr, 32'h3000_0040);
        tick(6);
        check_issued("reissue", '{32'h3000_0040, 32'h3000_0080});

        // Backpressure with a pending miss arriving during the stall.
        issued.delete();
        prefetch_req_rdy = 1'b0;
        pulse_miss(32'h5000_0000, 8'd7);
        for (int i = 1; i <= 5; i++) begin
            check("stall_vld", prefetch_req_vld, 1'b1);
            check("stall_addr", prefetch_req_pld.addr, 32'h5000_0040);
            if (i == 2) begin
                miss_for_prefetch       = 1'b1;
                miss_addr_for_prefetch  = 32'h2000_0000;
                miss_txnid_for_prefetch = 8'd9;
            end
            if (i == 3) miss_for_prefetch = 1'b0;
            if (i == 5) prefetch_req_rdy = 1'b1;
            tick(1);
        end
        check("pend_gap_vld", prefetch_req_vld, 1'b0);
        tick(1);
        check("pend_vld", prefetch_req_vld, 1'b1);
        check("pend_addr", prefetch_req_pld.addr, 32'h2000_0040);
        check("pend_txnid", prefetch_req_pld.txnid, 8'd9);
        tick(6);
        check_issued("pend", '{32'h5000_0040, 32'h2000_0040, 32'h2000_0080});

        // Asynchronous reset while a request is outstanding.
        issued.delete();
        prefetch_req_rdy = 1'b0;
        pulse_miss(32'h6000_0000, 8'd8);
        check("prereset_vld", prefetch_req_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_vld", prefetch_req_vld, 1'b0);
        check("async_reset_pld", prefetch_req_pld, '0);
        tick(2);
        rst_n            = 1'b1;
        prefetch_req_rdy = 1'b1;
        count_vld(5, hi);
        check("post_reset_no_vld", hi, 0);
        check("post_reset_issued", issued.size(), 0);
        pulse_miss(32'h6000_0000, 8'd8);
        check("post_reset_addr", prefetch_req_pld.addr, 32'h6000_0040);
        tick(6);
        check_issued("post_reset", '{32'h6000_0040, 32'h6000_0080});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/icache_stream_prefetcher.md
Name: icache_stream_prefetcher

Overview:
Next-line stream prefetcher that feeds the icache request arbiter's prefetch port (prefetch_req_vld/rdy/pld). On each demand miss reported by the MSHR file (miss_for_prefetch, miss_addr_for_prefetch, miss_txnid_for_prefetch), it issues up to PREF_DEPTH sequential line-address prefetch requests. Requests are gated by MSHR headroom (pref_to_mshr_req_rdy) and filtered against recently issued lines. Streams never cross a page boundary.

Parameters:
PREF_DEPTH, 2, lines prefetched ahead of each miss line (1..8)
FILTER_NUM, 4, entries in the recently-issued line filter (power of 2)
LINE_OFFSET_WIDTH, 6, byte-offset bits of a cache line (64B)
PAGE_OFFSET_WIDTH, 12, byte-offset bits of a page (4KB); streams stop at a page crossing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prefetch_enable  in  1  global enable; low = no new streams and filter flush
miss_for_prefetch  in  1  single-cycle pulse: demand miss allocated in MSHR
miss_addr_for_prefetch  in  req_addr_t  miss address
miss_txnid_for_prefetch  in  ICACHE_REQ_TXNID_WIDTH  miss txnid
pref_to_mshr_req_rdy  in  1  MSHR has a free entry for a prefetch
prefetch_req_vld  out  1  prefetch request valid
prefetch_req_rdy  in  1  arbiter accepts the request
prefetch_req_pld  out  pc_req_t  addr/txnid/opcode of the prefetch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; prefetch_req_vld=0; prefetch_req_pld=0; count=0; pending_vld=0; all filter valid bits 0. Reset mid-stream drops the stream and any pending miss. The first cycle after rst_n rises is IDLE.
- Line address: la = addr >> LINE_OFFSET_WIDTH. Candidate = base_la + count + 1, with modulo wrap at the la width.
- FSM IDLE:
  - On miss_for_prefetch & prefetch_enable: capture base_la, txnid; count=0; go ISSUE. Earliest prefetch_req_vld is the next cycle (1-cycle latency; outputs registered).
- FSM ISSUE, evaluated per cycle when no request is outstanding:
  - Candidate page bits (addr[MSB:PAGE_OFFSET_WIDTH]) differ from base page -> terminate and go IDLE; no request.
  - Candidate hits a valid filter entry -> skip this cycle (count++, vld stays 0).
  - Else, if pref_to_mshr_req_rdy=1 -> register vld=1 and pld = {addr=candidate<<LINE_OFFSET_WIDTH, txnid=captured txnid, opcode=PREF_OPCODE}.
  - Else wait; vld stays 0.
- Handshake: once vld=1, vld and pld hold stable until prefetch_req_rdy=1. pref_to_mshr_req_rdy dropping does not retract vld.
- On vld&rdy: vld=0 next cycle; candidate written into the filter at the round-robin pointer (pointer++ modulo FILTER_NUM); count++.
- Stream end: when count==PREF_DEPTH with no outstanding request, go IDLE.
- New miss while in ISSUE: latched into the 1-entry pending register (a later miss overwrites an earlier one).
  - Applied at the next cycle with no outstanding request: replaces base/txnid, count=0, stay ISSUE.
  - A pending miss present at stream end starts immediately instead of going IDLE.
- Miss and handshake in the same cycle: handshake completes first; the miss becomes the pending miss and is applied the following cycle.
- prefetch_enable=0:
  - Clears all filter valid bits and pending_vld. Misses are ignored.
  - If vld=0, go IDLE next cycle. If vld=1, hold until accepted (that entry is not filtered), then go IDLE.
- At most one request outstanding; throughput is 1 request per 2 cycles (the issue cycle plus the accept cycle).

Decomposition:
- Shared package (toy_pack): PREF_OPCODE constant, pref_state_e {IDLE, ISSUE}, icache line-address type derived from req_addr_t and LINE_OFFSET_WIDTH.
- One sub-module: icache_pref_line_filter. FILTER_NUM-entry fully associative register CAM; inputs lookup_la and insert_vld/insert_la, flush; output hit (combinational); round-robin replacement.

Test Plan:
- Basic stream: enable=1, PREF_DEPTH=2, both rdys=1, miss addr 0x1000_0040, txnid 5 -> requests 0x1000_0080 then 0x1000_00C0, each txnid 5, opcode PREF_OPCODE; first vld 1 cycle after miss; IDLE after the second accept.
- Filter: after the basic stream, miss at 0x1000_0080 -> candidate 0x1000_00C0 skipped; only 0x1000_0100 issued.
- Page boundary: miss 0x1000_0FC0 -> candidate 0x1000_1000 crosses page; no vld ever; IDLE within 2 cycles.
- Backpressure plus pending miss: prefetch_req_rdy=0 for 5 cycles with vld=1 -> pld stable all 5 cycles. A miss at 0x2000_0000 during the stall is issued as 0x2000_0040 right after the stalled request's accept cycle (the original stream is dropped).
- MSHR gating and disable:
  - pref_to_mshr_req_rdy=0 after a miss -> vld stays 0 until it rises.
  - prefetch_enable dropped with vld=0 -> IDLE next cycle, filter empty (a re-miss on the same addr re-issues the same lines).
- Async reset mid-stream with vld=1: assert rst_n=0 off-edge -> vld=0 immediately; no requests after release until a new miss.
